// File: rtl/dma_rq_rd_issue.sv
// -----------------------------------------------------------------------------
// dma_rq_rd_issue
//
// Splits one host-read descriptor (byte address, byte length) into PCIe Memory
// Read requests. Each request is bounded by the maximum read request size and
// by 4 KB address boundaries. It is issued as a single-beat RQ AXI-Stream TLP
// that carries a free tag taken from a window of C_WINDOW_SIZE tags.
// Outstanding tags and their expected dword counts are published to the
// completion stage. The completion stage retires tags through COMPLETED_TAGS.
// DONE pulses once every tag of the descriptor has retired.
//
// Optional feature (macro DMA_RQ_RD_TIMEOUT_EN):
//   A watchdog counts cycles spent in ALLOC/WAIT while tags are outstanding.
//   When it expires, it raises the sticky ERROR flag, forgets all tags and
//   finishes the descriptor so that DONE still pulses.
//   Without the macro, ERROR is tied low. A lost completion then parks the
//   block in WAIT until reset.
//
// Ports:
//   CLK, RST_N              clock, asynchronous active-low reset
//   DESC_VALID/READY        descriptor handshake
//   DESC_ADDR[63:0]         host byte address (dword aligned)
//   DESC_LEN[31:0]          length in bytes (multiple of 4, 0 allowed)
//   M_AXIS_RQ_*             requester request stream, one beat per TLP
//   CURRENT_WINDOW_SIZE     runtime cap on outstanding tags (0 = C_WINDOW_SIZE)
//   BUSY_TAGS               tag j outstanding
//   SIZE_TAGS               expected dwords of tag j at [11j+10:11j]
//   COMPLETED_TAGS          one-cycle retire pulses from the completion stage
//   DONE                    one-cycle pulse at descriptor completion
//   ERROR                   sticky watchdog error, cleared on next accept
// -----------------------------------------------------------------------------
module dma_rq_rd_issue #(
   parameter int C_BUS_DATA_WIDTH        = 256,
   parameter int C_BUS_KEEP_WIDTH        = C_BUS_DATA_WIDTH / 32,
   parameter int C_WINDOW_SIZE           = 16,
   parameter int C_LOG2_MAX_READ_REQUEST = 12,
   parameter int C_TIMEOUT_CYCLES        = 65535
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic                          DESC_VALID,
   output logic                          DESC_READY,
   input  logic [63:0]                   DESC_ADDR,
   input  logic [31:0]                   DESC_LEN,
   output logic [C_BUS_DATA_WIDTH-1:0]   M_AXIS_RQ_TDATA,
   output logic [59:0]                   M_AXIS_RQ_TUSER,
   output logic                          M_AXIS_RQ_TLAST,
   output logic [C_BUS_KEEP_WIDTH-1:0]   M_AXIS_RQ_TKEEP,
   output logic                          M_AXIS_RQ_TVALID,
   input  logic                          M_AXIS_RQ_TREADY,
   input  logic [63:0]                   CURRENT_WINDOW_SIZE,
   output logic [C_WINDOW_SIZE-1:0]      BUSY_TAGS,
   output logic [C_WINDOW_SIZE*11-1:0]   SIZE_TAGS,
   input  logic [C_WINDOW_SIZE-1:0]      COMPLETED_TAGS,
   output logic                          DONE,
   output logic                          ERROR
);

   localparam int          TAG_W  = (C_WINDOW_SIZE > 1) ? $clog2(C_WINDOW_SIZE) : 1;
   localparam logic [12:0] MAX_RR = 13'(2 ** C_LOG2_MAX_READ_REQUEST);

   if (C_LOG2_MAX_READ_REQUEST < 7 || C_LOG2_MAX_READ_REQUEST > 12 ||
       C_WINDOW_SIZE < 1 || C_WINDOW_SIZE > 256 || C_BUS_DATA_WIDTH < 128 ||
       C_TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("dma_rq_rd_issue: illegal parameter combination");
   end

   typedef enum logic [2:0] {S_IDLE, S_ALLOC, S_SEND, S_WAIT, S_FINISH} state_t;

   state_t                     state, state_nxt;
   logic                       out_of_reset;
   logic [63:0]                addr_q;
   logic [31:0]                remaining_q;
   logic [12:0]                chunk_q;      // bytes of the registered TLP, <= 4096
   logic [TAG_W-1:0]           tag_q;
   logic [C_WINDOW_SIZE-1:0]   busy_q;
   logic [C_WINDOW_SIZE*11-1:0] size_q;

   logic                       desc_hs, rq_hs, alloc_ok, wd_fire;
   logic [10:0]                dw_q;
   logic [12:0]                to_boundary, limit, chunk_c;
   logic [TAG_W-1:0]           free_tag;
   logic                       free_found;
   logic [31:0]                busy_cnt, eff_window;
   logic [C_WINDOW_SIZE-1:0]   set_mask;

   assign DESC_READY = out_of_reset && (state == S_IDLE);
   assign desc_hs    = DESC_VALID && DESC_READY;
   assign rq_hs      = (state == S_SEND) && M_AXIS_RQ_TREADY;
   assign dw_q       = chunk_q[12:2];

   // Chunk size, window occupancy and lowest free tag, all from registered state.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      to_boundary = 13'd4096 - {1'b0, addr_q[11:0]};
      limit       = (MAX_RR < to_boundary) ? MAX_RR : to_boundary;
      chunk_c     = (remaining_q < 32'(limit)) ? remaining_q[12:0] : limit;

      if (CURRENT_WINDOW_SIZE == 64'd0 || CURRENT_WINDOW_SIZE > 64'(C_WINDOW_SIZE))
         eff_window = 32'(C_WINDOW_SIZE);
      else
         eff_window = CURRENT_WINDOW_SIZE[31:0];

      busy_cnt   = '0;
      free_found = 1'b0;
      free_tag   = '0;
      // Scan downwards so the lowest free index is the one left standing.
      for (int j = C_WINDOW_SIZE - 1; j >= 0; j--) begin
         busy_cnt = busy_cnt + 32'(busy_q[j]);
         if (!busy_q[j]) begin
            free_found = 1'b1;
            free_tag   = TAG_W'(j);
         end
      end

      set_mask = '0;
      if (rq_hs) set_mask[tag_q] = 1'b1;
   end

   assign alloc_ok = (state == S_ALLOC) && free_found && (busy_cnt < eff_window) && !wd_fire;

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (desc_hs) state_nxt = (DESC_LEN == 32'd0) ? S_FINISH : S_ALLOC;
         S_ALLOC:  if (alloc_ok) state_nxt = S_SEND;
         S_SEND:   if (rq_hs) state_nxt = (remaining_q != 32'(chunk_q)) ? S_ALLOC : S_WAIT;
         S_WAIT:   if (busy_q == '0) state_nxt = S_FINISH;
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
      if (wd_fire) state_nxt = S_FINISH;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state        <= S_IDLE;
         out_of_reset <= 1'b0;
      end else begin
         state        <= state_nxt;
         out_of_reset <= 1'b1;
      end
   end

   // NOTE: the small SIZE_TAGS array is reset too, so it reads zero after reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         addr_q      <= '0;
         remaining_q <= '0;
         chunk_q     <= '0;
         tag_q       <= '0;
         busy_q      <= '0;
         size_q      <= '0;
      end else begin
         // A retire and a set of a different tag in the same cycle both land.
         busy_q <= (busy_q & ~COMPLETED_TAGS) | set_mask;
         if (desc_hs) begin
            addr_q      <= DESC_ADDR;
            remaining_q <= DESC_LEN;
         end
         if (alloc_ok) begin
            chunk_q <= chunk_c;
            tag_q   <= free_tag;
         end
         if (rq_hs) begin
            addr_q                          <= addr_q + 64'(chunk_q);
            remaining_q                     <= remaining_q - 32'(chunk_q);
            size_q[int'(tag_q)*11 +: 11]    <= dw_q;
         end
         if (wd_fire) begin
            busy_q      <= '0;
            remaining_q <= '0;
         end
      end
   end

`ifdef DMA_RQ_RD_TIMEOUT_EN
   logic [31:0] wd_cnt;
   logic        wd_active;
   logic        error_q;

   assign wd_active = ((state == S_ALLOC) || (state == S_WAIT)) && (busy_q != '0);
   assign wd_fire   = wd_active && (wd_cnt >= 32'(C_TIMEOUT_CYCLES));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wd_cnt  <= '0;
         error_q <= 1'b0;
      end else begin
         if (rq_hs || (COMPLETED_TAGS != '0) || !wd_active || wd_fire) wd_cnt <= '0;
         else                                                            wd_cnt <= wd_cnt + 32'd1;
         if (desc_hs)      error_q <= 1'b0;
         else if (wd_fire) error_q <= 1'b1;
      end
   end
   assign ERROR = error_q;
`else
   assign wd_fire = 1'b0;
   assign ERROR   = 1'b0;
`endif

   // TLP fields come straight from registers that only move on a handshake,
   // so they are stable for as long as TVALID waits for TREADY.
   always_comb begin
      M_AXIS_RQ_TDATA = '0;
      M_AXIS_RQ_TUSER = '0;
      M_AXIS_RQ_TKEEP = '0;
      M_AXIS_RQ_TLAST = 1'b0;
      if (state == S_SEND) begin
         M_AXIS_RQ_TDATA[63:2]   = addr_q[63:2];
         M_AXIS_RQ_TDATA[74:64]  = dw_q;
         M_AXIS_RQ_TDATA[103:96] = 8'(tag_q);
         M_AXIS_RQ_TUSER[3:0]    = 4'hF;
         M_AXIS_RQ_TUSER[7:4]    = (dw_q == 11'd1) ? 4'h0 : 4'hF;
         M_AXIS_RQ_TKEEP         = C_BUS_KEEP_WIDTH'(4'hF);
         M_AXIS_RQ_TLAST         = 1'b1;
      end
   end

   assign M_AXIS_RQ_TVALID = (state == S_SEND);
   assign BUSY_TAGS        = busy_q;
   assign SIZE_TAGS        = size_q;
   assign DONE             = (state == S_FINISH);

endmodule

// File: tb/tb_dma_rq_rd_issue.sv
`timescale 1ns/1ps
module tb_dma_rq_rd_issue;

   localparam int DW = 256;
   localparam int KW = DW / 32;
   localparam int WS = 16;

   logic            CLK = 1'b0;
   logic            RST_N = 1'b0;
   logic            DESC_VALID = 1'b0;
   logic            DESC_READY;
   logic [63:0]     DESC_ADDR = '0;
   logic [31:0]     DESC_LEN = '0;
   logic [DW-1:0]   M_AXIS_RQ_TDATA;
   logic [59:0]     M_AXIS_RQ_TUSER;
   logic            M_AXIS_RQ_TLAST;
   logic [KW-1:0]   M_AXIS_RQ_TKEEP;
   logic            M_AXIS_RQ_TVALID;
   logic            M_AXIS_RQ_TREADY = 1'b1;
   logic [63:0]     CURRENT_WINDOW_SIZE = '0;
   logic [WS-1:0]   BUSY_TAGS;
   logic [WS*11-1:0] SIZE_TAGS;
   logic [WS-1:0]   COMPLETED_TAGS = '0;
   logic            DONE;
   logic            ERROR;

   dma_rq_rd_issue #(
      .C_BUS_DATA_WIDTH(DW), .C_BUS_KEEP_WIDTH(KW), .C_WINDOW_SIZE(WS),
      .C_LOG2_MAX_READ_REQUEST(12), .C_TIMEOUT_CYCLES(100)
   ) dut (
      .CLK(CLK), .RST_N(RST_N),
      .DESC_VALID(DESC_VALID), .DESC_READY(DESC_READY),
      .DESC_ADDR(DESC_ADDR), .DESC_LEN(DESC_LEN),
      .M_AXIS_RQ_TDATA(M_AXIS_RQ_TDATA), .M_AXIS_RQ_TUSER(M_AXIS_RQ_TUSER),
      .M_AXIS_RQ_TLAST(M_AXIS_RQ_TLAST), .M_AXIS_RQ_TKEEP(M_AXIS_RQ_TKEEP),
      .M_AXIS_RQ_TVALID(M_AXIS_RQ_TVALID), .M_AXIS_RQ_TREADY(M_AXIS_RQ_TREADY),
      .CURRENT_WINDOW_SIZE(CURRENT_WINDOW_SIZE),
      .BUSY_TAGS(BUSY_TAGS), .SIZE_TAGS(SIZE_TAGS),
      .COMPLETED_TAGS(COMPLETED_TAGS), .DONE(DONE), .ERROR(ERROR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [63:0] addr;
      logic [10:0] dw;
      logic [7:0]  tag;
   } tlp_t;

   tlp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   hs_count = 0;
   int   last_hs_cyc = -1;
   int   prev_hs_cyc = -1;
   int   tv_rise_cyc = -1;
   int   done_count = 0;
   int   done_cyc = -1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic tlp_t mk(input logic [63:0] a, input logic [10:0] d, input logic [7:0] t);
      tlp_t e;
      e.addr = a; e.dw = d; e.tag = t;
      return e;
   endfunction

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   // Output monitor: scoreboard pop on every RQ handshake, plus event timestamps.
   initial begin
      tlp_t e;
      logic tv_prev;
      tv_prev = 1'b0;
      forever begin
         @(negedge CLK);
         if (RST_N) begin
            if (M_AXIS_RQ_TVALID && !tv_prev) tv_rise_cyc = cyc;
            if (M_AXIS_RQ_TVALID && M_AXIS_RQ_TREADY) begin
               hs_count++;
               prev_hs_cyc = last_hs_cyc;
               last_hs_cyc = cyc;
               if (exp_q.size() == 0) begin
                  check("unexpected_tlp", 64'(1), 64'(0));
               end else begin
                  e = exp_q.pop_front();
                  check("tlp_addr", M_AXIS_RQ_TDATA[63:0], e.addr);
                  check("tlp_dwords", 64'(M_AXIS_RQ_TDATA[74:64]), 64'(e.dw));
                  check("tlp_tag", 64'(M_AXIS_RQ_TDATA[103:96]), 64'(e.tag));
                  check("tlp_zero_fields",
                        64'({|M_AXIS_RQ_TDATA[95:75], |M_AXIS_RQ_TDATA[DW-1:104]}), 64'(0));
                  check("tlp_tuser", 64'(M_AXIS_RQ_TUSER), (e.dw == 11'd1) ? 64'h0F : 64'hFF);
                  check("tlp_keep_last", 64'({M_AXIS_RQ_TKEEP, M_AXIS_RQ_TLAST}),
                        64'({KW'(4'hF), 1'b1}));
               end
            end
            if (DONE) begin
               done_count++;
               done_cyc = cyc;
            end
            tv_prev = M_AXIS_RQ_TVALID;
         end else begin
            tv_prev = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_desc(input logic [63:0] a, input logic [31:0] l, output int acc);
      step();
      DESC_ADDR  = a;
      DESC_LEN   = l;
      DESC_VALID = 1'b1;
      acc = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (DESC_READY) begin
            acc = cyc;
            break;
         end
      end
      if (acc < 0) check("desc_accept_timeout", 64'(0), 64'(1));
      step();
      DESC_VALID = 1'b0;
   endtask

   task automatic retire(input logic [WS-1:0] mask, output int k);
      step();
      COMPLETED_TAGS = mask;
      k = cyc;
      step();
      COMPLETED_TAGS = '0;
   endtask

   task automatic wait_hs(input int n, input string tag);
      for (int i = 0; i < 400; i++) begin
         @(negedge CLK);
         if (hs_count >= n) return;
      end
      check(tag, 64'(hs_count), 64'(n));
   endtask

   task automatic wait_done(input int n, input string tag);
      for (int i = 0; i < 400; i++) begin
         @(negedge CLK);
         if (done_count >= n) return;
      end
      check(tag, 64'(done_count), 64'(n));
   endtask

   initial begin
      int acc, k, h0, d0, r0;
      logic [DW-1:0] cap_data;
      logic [59:0]   cap_user;
      logic          seen;

      // ---------------- reset state ----------------
      repeat (3) @(negedge CLK);
      check("rst_desc_ready", 64'(DESC_READY), 64'(0));
      check("rst_tvalid", 64'(M_AXIS_RQ_TVALID), 64'(0));
      check("rst_outputs_zero", 64'({|M_AXIS_RQ_TDATA, |M_AXIS_RQ_TUSER, |M_AXIS_RQ_TKEEP,
                                      M_AXIS_RQ_TLAST, |BUSY_TAGS, |SIZE_TAGS, DONE, ERROR}), 64'(0));
      step();
      RST_N = 1'b1;
      repeat (2) step();
      @(negedge CLK);
      check("post_rst_desc_ready", 64'(DESC_READY), 64'(1));

      // ---------------- single 256-byte read, one-tag window ----------------
      CURRENT_WINDOW_SIZE = 64'd1;
      h0 = hs_count; d0 = done_count;
      exp_q.push_back(mk(64'h1000, 11'd64, 8'd0));
      send_desc(64'h1000, 32'd256, acc);
      wait_hs(h0 + 1, "t1_hs_timeout");
      check("t1_tvalid_latency", 64'(tv_rise_cyc), 64'(acc + 2));
      step();
      @(negedge CLK);
      check("t1_busy", 64'(BUSY_TAGS), 64'h0001);
      check("t1_size_tag0", 64'(SIZE_TAGS[10:0]), 64'd64);
      check("t1_no_early_done", 64'(done_count), 64'(d0));
      retire(16'h0001, k);
      wait_done(d0 + 1, "t1_done_timeout");
      check("t1_done_latency", 64'(done_cyc), 64'(k + 2));
      repeat (3) step();
      @(negedge CLK);
      check("t1_busy_cleared", 64'(BUSY_TAGS), 64'h0);
      check("t1_done_once", 64'(done_count), 64'(d0 + 1));

      // ---------------- 20 KB read, window of 4, stall and tag reuse ----------------
      CURRENT_WINDOW_SIZE = 64'd4;
      h0 = hs_count; d0 = done_count;
      for (int i = 0; i < 4; i++) exp_q.push_back(mk(64'(i) * 64'h1000, 11'd1024, 8'(i)));
      send_desc(64'h0, 32'd20480, acc);
      wait_hs(h0 + 4, "t2_hs4_timeout");
      repeat (10) step();
      @(negedge CLK);
      check("t2_stall_tvalid", 64'(M_AXIS_RQ_TVALID), 64'(0));
      check("t2_stall_busy", 64'(BUSY_TAGS), 64'h000F);
      check("t2_stall_hs", 64'(hs_count), 64'(h0 + 4));
      retire(16'h0020, k);             // tag 5 is not busy: must be ignored
      repeat (3) step();
      @(negedge CLK);
      check("t2_idle_retire_ignored", 64'({BUSY_TAGS, M_AXIS_RQ_TVALID}), 64'({16'h000F, 1'b0}));
      exp_q.push_back(mk(64'h4000, 11'd1024, 8'd2));
      retire(16'h0004, k);
      wait_hs(h0 + 5, "t2_hs5_timeout");
      check("t2_reuse_latency", 64'(last_hs_cyc), 64'(k + 2));
      step();
      @(negedge CLK);
      check("t2_busy_after_reuse", 64'(BUSY_TAGS), 64'h000F);
      check("t2_size_tag2", 64'(SIZE_TAGS[2*11 +: 11]), 64'd1024);
      retire(16'h000F, k);
      wait_done(d0 + 1, "t2_done_timeout");
      check("t2_done_latency", 64'(done_cyc), 64'(k + 2));

      // ---------------- 4 KB boundary cut ----------------
      CURRENT_WINDOW_SIZE = 64'd0;
      h0 = hs_count; d0 = done_count;
      exp_q.push_back(mk(64'h0F00, 11'd64, 8'd0));
      exp_q.push_back(mk(64'h1000, 11'd64, 8'd1));
      send_desc(64'h0F00, 32'd512, acc);
      wait_hs(h0 + 2, "t3_hs_timeout");
      check("t3_back_to_back_latency", 64'(tv_rise_cyc), 64'(prev_hs_cyc + 2));
      step();
      @(negedge CLK);
      check("t3_busy", 64'(BUSY_TAGS), 64'h0003);
      retire(16'h0003, k);
      wait_done(d0 + 1, "t3_done_timeout");

      // ---------------- single dword, back-pressure ----------------
      h0 = hs_count; d0 = done_count;
      M_AXIS_RQ_TREADY = 1'b0;
      exp_q.push_back(mk(64'h0, 11'd1, 8'd0));
      send_desc(64'h0, 32'd4, acc);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge CLK);
         seen = M_AXIS_RQ_TVALID;
      end
      check("t4_tvalid_seen", 64'(seen), 64'(1));
      cap_data = M_AXIS_RQ_TDATA;
      cap_user = M_AXIS_RQ_TUSER;
      for (int i = 0; i < 5; i++) begin
         step();
         @(negedge CLK);
         check("t4_hold", 64'({M_AXIS_RQ_TVALID, M_AXIS_RQ_TDATA == cap_data,
                               M_AXIS_RQ_TUSER == cap_user}), 64'h7);
      end
      check("t4_no_hs_while_stalled", 64'(hs_count), 64'(h0));
      step();
      M_AXIS_RQ_TREADY = 1'b1;
      wait_hs(h0 + 1, "t4_hs_timeout");
      repeat (4) step();
      @(negedge CLK);
      check("t4_exactly_one_hs", 64'(hs_count), 64'(h0 + 1));
      check("t4_size_tag0", 64'(SIZE_TAGS[10:0]), 64'd1);
      retire(16'h0001, k);
      wait_done(d0 + 1, "t4_done_timeout");

      // ---------------- zero-length descriptor ----------------
      h0 = hs_count; d0 = done_count; r0 = tv_rise_cyc;
      send_desc(64'h5000, 32'd0, acc);
      wait_done(d0 + 1, "t5_done_timeout");
      check("t5_done_latency", 64'(done_cyc), 64'(acc + 1));
      repeat (2) step();
      @(negedge CLK);
      check("t5_no_tlp", 64'({hs_count == h0, tv_rise_cyc == r0}), 64'h3);
      check("t5_done_single", 64'({DONE, done_count == d0 + 1}), 64'h1);
      check("error_low", 64'(ERROR), 64'(`ifdef DMA_RQ_RD_TIMEOUT_EN 0 `else 0 `endif));

`ifdef DMA_RQ_RD_TIMEOUT_EN
      // ---------------- watchdog on a lost completion ----------------
      h0 = hs_count; d0 = done_count;
      exp_q.push_back(mk(64'h2000, 11'd64, 8'd0));
      send_desc(64'h2000, 32'd256, acc);
      wait_hs(h0 + 1, "wd_hs_timeout");
      wait_done(d0 + 1, "wd_done_timeout");
      check("wd_delay_window", 64'({(done_cyc - last_hs_cyc) >= 95, (done_cyc - last_hs_cyc) <= 110}), 64'h3);
      step();
      @(negedge CLK);
      check("wd_error_busy", 64'({ERROR, BUSY_TAGS}), 64'({1'b1, 16'h0}));
      d0 = done_count;
      send_desc(64'h0, 32'd0, acc);
      @(negedge CLK);
      check("wd_error_cleared", 64'(ERROR), 64'(0));
      wait_done(d0 + 1, "wd_clear_done_timeout");
`endif

      // ---------------- reset mid-operation ----------------
      h0 = hs_count; d0 = done_count;
      exp_q.push_back(mk(64'h3000, 11'd64, 8'd0));
      send_desc(64'h3000, 32'd256, acc);
      wait_hs(h0 + 1, "t6_hs_timeout");
      step();
      RST_N = 1'b0;
      @(negedge CLK);
      check("t6_reset_abort", 64'({DESC_READY, M_AXIS_RQ_TVALID, BUSY_TAGS}), 64'(0));
      step();
      RST_N = 1'b1;
      retire(16'h0001, k);             // late completion for a forgotten tag
      repeat (4) step();
      @(negedge CLK);
      check("t6_late_retire_ignored", 64'({BUSY_TAGS, DESC_READY}), 64'({16'h0, 1'b1}));
      check("t6_no_done", 64'(done_count), 64'(d0));
      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
